// File: rtl/e203_tb_irq_sched_pkg.sv
// Shared types and constants for the E203 bench interrupt scheduler.
package e203_tb_irq_sched_pkg;

    // Per-channel scheduler state
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        ASSERT = 2'd2,
        HALT   = 2'd3
    } chan_state_e;

    // Galois feedback mask for the 16-bit delay LFSR
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    // Default commit PCs of the standard interrupt test program
    localparam logic [31:0] DEF_ARM_PC     = 32'h8000015C;
    localparam logic [31:0] DEF_TOHOST_PC  = 32'h80000086;
    localparam logic [31:0] DEF_EXT_ACK_PC = 32'h800000A6;
    localparam logic [31:0] DEF_SFT_ACK_PC = 32'h800000BE;
    localparam logic [31:0] DEF_TMR_ACK_PC = 32'h800000D6;

    // An all-zero Galois LFSR never leaves zero, so a zero seed is remapped
    function automatic logic [15:0] fix_seed(input logic [15:0] seed);
        return (seed == 16'h0000) ? 16'h0001 : seed;
    endfunction

    // One step of the right-shifting Galois LFSR
    function automatic logic [15:0] lfsr_next(input logic [15:0] value);
        return (value >> 1) ^ (value[0] ? LFSR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/e203_tb_irq_chan.sv
// One interrupt channel: free-running LFSR, random delay, hold-until-ack IRQ
// and a serviced-interrupt counter. DLY_W must be between 1 and 16.
module e203_tb_irq_chan
    import e203_tb_irq_sched_pkg::*;
#(
    parameter int          DLY_W = 10,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic        hfclk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        armed,
    input  logic        stopped,
    input  logic        hit_ack,
    output logic        irq,
    output logic [15:0] srv
);

    localparam logic [DLY_W:0] CNT_ONE = (DLY_W + 1)'(1);

    logic [15:0]    lfsr;
    chan_state_e    state;
    logic [DLY_W:0] cnt;
    logic [DLY_W:0] new_dly;

    // Fresh delay in the range 1..2^DLY_W drawn from the current LFSR value
    assign new_dly = {1'b0, lfsr[DLY_W-1:0]} + CNT_ONE;

    // LFSR runs every cycle from reset exit, independent of enable
    always_ff @(posedge hfclk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= fix_seed(SEED);
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    // Channel FSM with registered IRQ drive and serviced count
    always_ff @(posedge hfclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            irq   <= 1'b0;
            srv   <= '0;
        end else if (!en) begin
            state <= IDLE;
            cnt   <= '0;
            irq   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (armed) begin
                        state <= DELAY;
                        cnt   <= new_dly;
                    end
                end
                DELAY: begin
                    if (cnt == CNT_ONE) begin
                        cnt <= '0;
                        if (stopped) begin
                            state <= HALT;
                        end else begin
                            state <= ASSERT;
                            irq   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ASSERT: begin
                    if (hit_ack) begin
                        irq <= 1'b0;
                        srv <= srv + 16'd1;
                        if (stopped) begin
                            state <= HALT;
                            cnt   <= '0;
                        end else begin
                            state <= DELAY;
                            cnt   <= new_dly;
                        end
                    end
                end
                HALT: begin
                    irq <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/e203_tb_irq_sched.sv
// Interrupt-stimulus scheduler: arms on a commit PC, drives three random
// IRQ channels and winds down after enough tohost writes.
module e203_tb_irq_sched
    import e203_tb_irq_sched_pkg::*;
#(
    parameter int               PC_W       = 32,
    parameter logic [PC_W-1:0]  ARM_PC     = PC_W'(DEF_ARM_PC),
    parameter logic [PC_W-1:0]  TOHOST_PC  = PC_W'(DEF_TOHOST_PC),
    parameter logic [PC_W-1:0]  EXT_ACK_PC = PC_W'(DEF_EXT_ACK_PC),
    parameter logic [PC_W-1:0]  SFT_ACK_PC = PC_W'(DEF_SFT_ACK_PC),
    parameter logic [PC_W-1:0]  TMR_ACK_PC = PC_W'(DEF_TMR_ACK_PC),
    parameter int               DLY_W      = 10,
    parameter logic [31:0]      STOP_CNT   = 32'd32,
    parameter logic [15:0]      SEED_EXT   = 16'hACE1,
    parameter logic [15:0]      SEED_SFT   = 16'h1D2C,
    parameter logic [15:0]      SEED_TMR   = 16'h7F31
) (
    input  logic            hfclk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            cmt_valid,
    input  logic [PC_W-1:0] cmt_pc,
    output logic            ext_irq_o,
    output logic            sft_irq_o,
    output logic            tmr_irq_o,
    output logic            armed_o,
    output logic            stopped_o,
    output logic            quiet_o,
    output logic [31:0]     tohost_cnt_o,
    output logic [15:0]     ext_srv_o,
    output logic [15:0]     sft_srv_o,
    output logic [15:0]     tmr_srv_o
);

    logic hit_arm;
    logic hit_tohost;
    logic hit_ext;
    logic hit_sft;
    logic hit_tmr;

    assign hit_arm    = cmt_valid & (cmt_pc == ARM_PC);
    assign hit_tohost = cmt_valid & (cmt_pc == TOHOST_PC);
    assign hit_ext    = cmt_valid & (cmt_pc == EXT_ACK_PC);
    assign hit_sft    = cmt_valid & (cmt_pc == SFT_ACK_PC);
    assign hit_tmr    = cmt_valid & (cmt_pc == TMR_ACK_PC);

    // Sticky arm flag, cleared whenever the scheduler is disabled
    always_ff @(posedge hfclk or negedge rst_n) begin
        if (!rst_n) begin
            armed_o <= 1'b0;
        end else if (!en) begin
            armed_o <= 1'b0;
        end else if (hit_arm) begin
            armed_o <= 1'b1;
        end
    end

    // Saturating tohost write counter, counts even while disabled
    always_ff @(posedge hfclk or negedge rst_n) begin
        if (!rst_n) begin
            tohost_cnt_o <= '0;
        end else if (hit_tohost && (tohost_cnt_o != 32'hFFFF_FFFF)) begin
            tohost_cnt_o <= tohost_cnt_o + 32'd1;
        end
    end

    assign stopped_o = (tohost_cnt_o > STOP_CNT);
    assign quiet_o   = stopped_o & ~ext_irq_o & ~sft_irq_o & ~tmr_irq_o;

    e203_tb_irq_chan #(.DLY_W(DLY_W), .SEED(SEED_EXT)) u_ext (
        .hfclk   (hfclk),
        .rst_n   (rst_n),
        .en      (en),
        .armed   (armed_o),
        .stopped (stopped_o),
        .hit_ack (hit_ext),
        .irq     (ext_irq_o),
        .srv     (ext_srv_o)
    );

    e203_tb_irq_chan #(.DLY_W(DLY_W), .SEED(SEED_SFT)) u_sft (
        .hfclk   (hfclk),
        .rst_n   (rst_n),
        .en      (en),
        .armed   (armed_o),
        .stopped (stopped_o),
        .hit_ack (hit_sft),
        .irq     (sft_irq_o),
        .srv     (sft_srv_o)
    );

    e203_tb_irq_chan #(.DLY_W(DLY_W), .SEED(SEED_TMR)) u_tmr (
        .hfclk   (hfclk),
        .rst_n   (rst_n),
        .en      (en),
        .armed   (armed_o),
        .stopped (stopped_o),
        .hit_ack (hit_tmr),
        .irq     (tmr_irq_o),
        .srv     (tmr_srv_o)
    );

endmodule
